// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_REQ requesters.
// Ports: clk, rst_n; per-requester req/write/addr/wdata in, ack/rdata_vld/err
// out; broadcast rdata, owner, busy; memory side mem_req/mem_write/mem_addr/
// mem_wdata out, mem_ack/mem_rdata_vld/mem_rdata in.
// Optional macro MEMARB_RD_TIMEOUT_EN adds a read-response timeout (TO_CYCLES).
module mem_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MEM_AW    = 16,
    parameter int MEM_DW    = 32,
    parameter int TO_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          write,
    input  logic [N_REQ*MEM_AW-1:0]   addr,
    input  logic [N_REQ*MEM_DW-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          rdata_vld,
    output logic [MEM_DW-1:0]         rdata,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic [N_REQ-1:0]          err,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [MEM_DW-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic                      mem_rdata_vld,
    input  logic [MEM_DW-1:0]         mem_rdata
);

    localparam int OW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_param_chk
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } state_t;

    state_t state, state_n;

    logic [OW-1:0]    last;
    logic [OW-1:0]    gnt;
    logic [OW-1:0]    cand;
    logic [N_REQ-1:0] own_oh;
    logic             rd_cap;
    logic             to_hit;

    assign own_oh = N_REQ'(1) << owner;

    // Scan offsets from farthest to nearest so the nearest set bit after
    // 'last' (with wrap) is the one left in gnt.
    always_comb begin
        gnt  = last;
        cand = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (int'(last) + i >= N_REQ)
                cand = OW'(int'(last) + i - N_REQ);
            else
                cand = OW'(int'(last) + i);
            if (req[cand])
                gnt = cand;
        end
    end

`ifdef MEMARB_RD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    logic [15:0] to_cnt;

    // Held at zero outside WAIT_RD, so it starts from 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state != WAIT_RD)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 16'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        rd_cap  = 1'b0;
        to_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req)
                    state_n = ISSUE;
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (mem_write) begin
                        state_n = DONE;
                    end else if (mem_rdata_vld) begin
                        rd_cap  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rdata_vld) begin
                    rd_cap  = 1'b1;
                    state_n = DONE;
                end
`ifdef MEMARB_RD_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    to_hit  = 1'b1;
                    state_n = DONE;
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= OW'(N_REQ - 1);
            owner     <= '0;
            busy      <= 1'b0;
            ack       <= '0;
            rdata_vld <= '0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEMARB_RD_TIMEOUT_EN
            err       <= '0;
`endif
        end else begin
            ack       <= '0;
            rdata_vld <= '0;
            busy      <= (state_n != IDLE);
`ifdef MEMARB_RD_TIMEOUT_EN
            err       <= '0;
`endif
            if (state == IDLE && |req) begin
                owner     <= gnt;
                last      <= gnt;
                mem_req   <= 1'b1;
                mem_write <= write[gnt];
                mem_addr  <= addr[gnt*MEM_AW +: MEM_AW];
                mem_wdata <= wdata[gnt*MEM_DW +: MEM_DW];
            end
            if (state == ISSUE && mem_ack)
                mem_req <= 1'b0;
            if (rd_cap) begin
                rdata     <= mem_rdata;
                rdata_vld <= own_oh;
            end
            if (state != DONE && state_n == DONE)
                ack <= own_oh;
            if (to_hit) begin
                rdata <= '0;
`ifdef MEMARB_RD_TIMEOUT_EN
                err   <= own_oh;
`endif
            end
        end
    end

`ifndef MEMARB_RD_TIMEOUT_EN
    assign err = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// completions; a negedge monitor pops and compares every ack/err pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  write = '0;
    logic [63:0] addr = '0;
    logic [127:0] wdata = '0;
    logic [3:0]  ack, rdata_vld, err;
    logic [31:0] rdata;
    logic [1:0]  owner;
    logic        busy;
    logic        mem_req, mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        mem_rdata_vld = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  rv;
        logic [3:0]  er;
        logic [31:0] rd;
        logic [1:0]  own;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(
        .N_REQ(4), .MEM_AW(16), .MEM_DW(32), .TO_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .write(write),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata_vld(rdata_vld),
        .rdata(rdata), .owner(owner), .busy(busy), .err(err),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] rv,
                        input logic [3:0] er, input logic [31:0] rd,
                        input logic [1:0] own);
        exp_t e;
        e.ack = a; e.rv = rv; e.er = er; e.rd = rd; e.own = own;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (ack != 0 || rdata_vld != 0 || err != 0)) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected", {52'd0, ack, rdata_vld, err}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_ack", 64'(ack), 64'(e.ack));
                chk("mon_rdata_vld", 64'(rdata_vld), 64'(e.rv));
                chk("mon_err", 64'(err), 64'(e.er));
                chk("mon_owner", 64'(owner), 64'(e.own));
                if (e.rv != 0)
                    chk("mon_rdata", 64'(rdata), 64'(e.rd));
            end
        end
    end

    initial begin
        logic [15:0] sa;
        logic [31:0] sd;
        int          n;
        int          prev;

        // reset state
        #12;
        chk("rst_ack", 64'(ack), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_rdata", 64'(rdata), 0);
        chk("rst_err", 64'(err), 0);
        rst_n = 1'b1;
        tick();

        // 1: single write from requester 0, mem_ack tied high
        req = 4'b0001; write = 4'b0001;
        addr[15:0] = 16'h0011; wdata[31:0] = 32'hFFFF_FFEE;
        mem_ack = 1'b1;
        push(4'b0001, 4'b0000, 4'b0000, 32'h0, 2'd0);
        tick();
        chk("t1_mem_req", 64'(mem_req), 1);
        chk("t1_mem_write", 64'(mem_write), 1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h0011);
        chk("t1_mem_wdata", 64'(mem_wdata), 64'hFFFF_FFEE);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_no_ack_yet", 64'(ack), 0);
        req = 4'b0000;
        tick();
        chk("t1_ack", 64'(ack), 64'b0001);
        chk("t1_mem_req_done", 64'(mem_req), 0);
        tick();
        chk("t1_ack_drop", 64'(ack), 0);
        chk("t1_idle", 64'(busy), 0);

        // 2: read from requester 1 with delayed accept and response
        mem_ack = 1'b0;
        req = 4'b0010; write = 4'b0000;
        addr[31:16] = 16'h0100;
        push(4'b0010, 4'b0010, 4'b0000, 32'hDEAD_BEEF, 2'd1);
        tick();
        chk("t2_owner", 64'(owner), 1);
        chk("t2_mem_addr", 64'(mem_addr), 64'h0100);
        chk("t2_mem_write", 64'(mem_write), 0);
        req = 4'b0000;
        mem_rdata_vld = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rdata_vld = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        chk("t2_mem_req_accepted", 64'(mem_req), 0);
        mem_ack = 1'b0;
        tick();
        tick();
        mem_rdata_vld = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rdata_vld = 1'b0;
        chk("t2_ack", 64'(ack), 64'b0010);
        chk("t2_rdata_vld", 64'(rdata_vld), 64'b0010);
        chk("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
        tick();
        chk("t2_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

        // 3: fairness from reset, all requesters writing continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            addr[k*16 +: 16] = 16'(16'h0A00 + k);
            wdata[k*32 +: 32] = 32'(32'hC0DE_0000 + k);
        end
        write = 4'b1111; mem_ack = 1'b1;
        for (int k = 0; k < 6; k++)
            push(4'(1 << (k % 4)), 4'b0000, 4'b0000, 32'h0, 2'(k % 4));
        req = 4'b1111;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!mem_req && n < 10) begin
                tick();
                n++;
            end
            if (!mem_req) begin
                chk("t3_grant_timeout", 64'(mem_req), 1);
                break;
            end
            if (k == 5)
                req = 4'b0000;
            chk("t3_owner", 64'(owner), 64'(k % 4));
            chk("t3_mem_addr", 64'(mem_addr), 64'(16'h0A00 + k % 4));
            if (prev >= 0)
                chk("t3_spacing", 64'(cyc - prev), 3);
            prev = cyc;
            tick();
        end
        tick();
        tick();

        // 4: backpressure on a write from requester 2
        mem_ack = 1'b0;
        req = 4'b0100; write = 4'b0100;
        addr[47:32] = 16'h0B0B; wdata[95:64] = 32'h5555_AAAA;
        push(4'b0100, 4'b0000, 4'b0000, 32'h0, 2'd2);
        tick();
        sa = mem_addr; sd = mem_wdata;
        chk("t4_owner", 64'(owner), 2);
        req = 4'b0000;
        addr[47:32] = 16'hFFFF; wdata[95:64] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_mem_req_held", 64'(mem_req), 1);
            chk("t4_addr_stable", 64'(mem_addr), 64'h0B0B);
            chk("t4_wdata_stable", 64'(mem_wdata), 64'h5555_AAAA);
            chk("t4_no_ack", 64'(ack), 0);
            if (k < 4)
                tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_ack", 64'(ack), 64'b0100);
        chk("t4_wdata_kept", 64'(mem_wdata), 64'(sd));
        chk("t4_addr_kept", 64'(mem_addr), 64'(sa));
        tick();

        // 5: reset while waiting for read data
        req = 4'b1000; write = 4'b0000; mem_ack = 1'b1;
        tick();
        chk("t5_owner", 64'(owner), 3);
        req = 4'b0000;
        tick();
        mem_ack = 1'b0;
        chk("t5_in_wait", 64'(busy), 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_mem_req", 64'(mem_req), 0);
        chk("t5_rst_owner", 64'(owner), 0);
        chk("t5_rst_mem_addr", 64'(mem_addr), 0);
        tick();
        rst_n = 1'b1;
        mem_rdata_vld = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        mem_rdata_vld = 1'b0; mem_ack = 1'b0;
        chk("t5_late_ack", 64'(ack), 0);
        chk("t5_late_rv", 64'(rdata_vld), 0);
        chk("t5_late_busy", 64'(busy), 0);
        chk("t5_late_rdata", 64'(rdata), 0);
        req = 4'b1001; write = 4'b1001; mem_ack = 1'b1;
        push(4'b0001, 4'b0000, 4'b0000, 32'h0, 2'd0);
        tick();
        chk("t5_next_owner", 64'(owner), 0);
        req = 4'b0000;
        tick();
        tick();

`ifdef MEMARB_RD_TIMEOUT_EN
        // 6: read accepted but never answered
        req = 4'b0010; write = 4'b0000; mem_ack = 1'b1;
        push(4'b0010, 4'b0000, 4'b0010, 32'h0, 2'd1);
        tick();
        req = 4'b0000;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("t6_no_ack_early", 64'(ack), 0);
            tick();
        end
        chk("t6_no_ack_last", 64'(ack), 0);
        tick();
        chk("t6_ack", 64'(ack), 64'b0010);
        chk("t6_err", 64'(err), 64'b0010);
        chk("t6_rdata_vld", 64'(rdata_vld), 0);
        chk("t6_rdata", 64'(rdata), 0);
        tick();
        req = 4'b0100; write = 4'b0100; mem_ack = 1'b1;
        push(4'b0100, 4'b0000, 4'b0000, 32'h0, 2'd2);
        tick();
        chk("t6_next_owner", 64'(owner), 2);
        req = 4'b0000;
        tick();
        tick();
`else
        chk("err_tied_low", 64'(err), 0);
`endif

        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory interface (mem_req/mem_write/mem_addr/mem_wdata out, read data back with a valid strobe) among N_REQ requesters, e.g. several matmul sequencers.
- Each requester presents one transaction at a time and gets a one-cycle ack on completion.
- Round-robin arbitration per transaction; the memory side has a registered request and an accept strobe.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MEM_AW, 16, address width
- MEM_DW, 32, data width
- TO_CYCLES, 256, read-response timeout in cycles (used only with the optional feature; 1..65535)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester transaction request; held until ack
- write  in  N_REQ  per-requester 1=write, 0=read
- addr  in  N_REQ*MEM_AW  flattened addresses; requester k at [k*MEM_AW +: MEM_AW]
- wdata  in  N_REQ*MEM_DW  flattened write data, same packing
- ack  out  N_REQ  one-cycle completion pulse to the owner
- rdata_vld  out  N_REQ  one-cycle pulse; asserted with ack on a successful read
- rdata  out  MEM_DW  read data; broadcast, valid while rdata_vld is high
- owner  out  $clog2(N_REQ)  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- err  out  N_REQ  timeout pulse (optional feature)
- mem_req  out  1  memory request
- mem_write  out  1  memory write enable
- mem_addr  out  MEM_AW  memory address
- mem_wdata  out  MEM_DW  memory write data
- mem_ack  in  1  memory accepts the presented request this cycle
- mem_rdata_vld  in  1  read data valid
- mem_rdata  in  MEM_DW  read data

Behaviour:
- Reset: every output is 0, state IDLE, round-robin pointer last = N_REQ-1, so requester 0 has first priority. All outputs are registered.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from (last+1) mod N_REQ upward with wrap; set last = owner = that index.
  - Register the owner's addr, wdata and write into mem_*, set mem_req=1, go to ISSUE.
  - mem_req therefore rises 1 cycle after req is sampled.
- ISSUE:
  - mem_* are held stable until mem_ack=1.
  - Write accepted: mem_req=0, go to DONE.
  - Read accepted: mem_req=0, go to WAIT_RD.
  - Read accepted and mem_rdata_vld=1 in the same cycle: capture mem_rdata and go to DONE directly.
- WAIT_RD: on mem_rdata_vld, capture mem_rdata into rdata and go to DONE.
- DONE:
  - Lasts exactly one cycle: ack[owner]=1; rdata_vld[owner]=1 if the transaction was a successful read. Then go to IDLE.
  - No arbitration happens in DONE, so a requester that sees ack can drop req or present a new transaction before the next IDLE sample.
- Throughput:
  - Zero-wait write: IDLE, ISSUE, DONE = 3 cycles per transaction.
  - Read: adds its response latency.
- Fields are captured at grant. A requester deasserting req or changing fields after grant does not affect the transaction; it still completes and ack still pulses.
- mem_rdata_vld outside WAIT_RD (and outside the ISSUE-read-accept case) is ignored.
- mem_wdata and mem_addr may hold their last values when idle; only mem_req qualifies them.
- Reset mid-transaction: immediate return to reset values. A late mem_ack or mem_rdata_vld after reset release is ignored while in IDLE.
- rdata holds its value until the next capture.

Optional Feature:
- MEMARB_RD_TIMEOUT_EN:
  - Defined: a 16-bit counter clears on entering WAIT_RD and increments each cycle there. At count == TO_CYCLES-1 with no mem_rdata_vld, go to DONE with ack[owner]=1, err[owner]=1, rdata_vld=0, rdata=0.
  - Undefined: WAIT_RD waits indefinitely; err is tied to 0 and no counter is instantiated.

Test Plan:
1. Single write: req[0]=1, write[0]=1, addr 0x0011, wdata 0xFFFFFFEE, mem_ack tied 1 -> mem_req/mem_write=1 with addr 0x0011, data 0xFFFFFFEE one cycle after req; ack[0] pulses the following cycle; mem_req=0 in DONE.
2. Read: req[1] read at addr 0x0100; mem_ack after 2 cycles; mem_rdata_vld 3 cycles later with 0xDEADBEEF -> ack[1] and rdata_vld[1] pulse together with rdata=0xDEADBEEF; owner=1.
3. Fairness: all 4 req held high, each re-presenting after ack, mem_ack=1 -> grant order 0,1,2,3,0,1; a new mem_req every 3 cycles.
4. Backpressure: mem_ack=0 for 5 cycles during a write -> mem_* stable and no ack for 5 cycles; completion follows the first mem_ack.
5. Reset during WAIT_RD, then mem_rdata_vld pulses after release -> all outputs 0 immediately; no ack or rdata_vld; next grant goes to requester 0.
6. With MEMARB_RD_TIMEOUT_EN and TO_CYCLES=8, a read accepted but never answered -> err[owner] and ack[owner] pulse after 8 cycles in WAIT_RD; rdata_vld stays 0; next arbitration proceeds.
